saturn_fetch: RTL and testbench
===============================

SATURN_FETCH -- requirements
Module: saturn_fetch

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, with ports named i_clk and i_reset.
REQ-002 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_load_pc  in  1  redirect request: flush and restart at i_new_pc.
- i_new_pc  in  20  redirect target address.
- i_inc_pc  in  1  decoder consumed the presented nibble.
- o_bus_req  out  1  nibble read request.
- o_bus_addr  out  20  read address.
- i_bus_ack  in  1  read completes this cycle.
- i_bus_data  in  4  nibble read, valid with i_bus_ack.
- o_pc  out  20  address of the presented nibble; drives decoder i_pc.
- o_nibble  out  4  presented nibble; drives decoder i_nibble.
- o_en_dec  out  1  nibble valid; drives decoder i_en_dec.
- o_stalled  out  1  equals !o_en_dec; drives decoder i_stalled.

Function
REQ-003 The block SHALL keep a 4-entry prefetch FIFO; each entry holds {addr[19:0], nibble[3:0]}.
- o_pc and o_nibble SHALL show the FIFO head.
- o_en_dec SHALL be 1 when the FIFO is non-empty.
REQ-004 A pop SHALL occur on an edge where o_en_dec && i_inc_pc && !i_load_pc.
- i_inc_pc with an empty FIFO SHALL be ignored.
REQ-005 A bus transfer SHALL complete on an edge where o_bus_req && i_bus_ack; i_bus_ack without o_bus_req SHALL be ignored.
REQ-006 Once raised, o_bus_req and o_bus_addr SHALL stay stable until the transfer completes; at most one transfer is outstanding.
REQ-007 A new request SHALL be raised only when FIFO count + outstanding < 4, so a push never overflows.
- Push and pop on the same edge SHALL leave the count unchanged.
REQ-008 Latency: a completion at edge N into an empty FIFO SHALL give o_en_dec=1, with the data on o_nibble, after edge N.
- Back-to-back completions SHALL allow one nibble per cycle.
REQ-009 The fetch address SHALL increment by 1 per completion and wrap from 20'hFFFFF to 20'h00000.
REQ-010 The state machine SHALL have the following states:
- IDLE: no request.
- REQ: request outstanding.
- DISCARD: request outstanding, data to be dropped.
REQ-011 State transitions SHALL be:
- IDLE->REQ when there is space.
- REQ->IDLE on completion when no space remains; otherwise REQ stays in REQ with the next address.
- REQ->DISCARD on i_load_pc without a same-cycle completion.
- DISCARD->REQ (at the new pc) on completion.
REQ-012 i_load_pc SHALL flush the FIFO (o_en_dec=0 after the edge) and set the fetch address to i_new_pc.
- i_load_pc SHALL take priority over a same-cycle pop and push.
- Data completing on the same edge as i_load_pc SHALL be discarded.
REQ-013 i_load_pc while in DISCARD SHALL update the restart address to the latest i_new_pc.
REQ-014 The FIFO SHALL never expose discarded or stale data: after a redirect, the first o_pc presented SHALL equal i_new_pc.

Reset
REQ-015 On i_reset=0, the block SHALL immediately clear:
- FIFO empty; o_en_dec=0; o_stalled=1.
- o_bus_req=0; o_bus_addr=0; o_pc=0; o_nibble=0.
- Fetch address = 20'h00000; state = IDLE.
REQ-016 Reset asserted mid-transfer SHALL abandon the transfer.
- After release, the first request SHALL be to address 0, issued on the first edge after release.

Structure
REQ-017 The address width (20), nibble width (4), FIFO depth (4) and the state encoding SHALL live in shared package saturn_pkg.
REQ-018 The FIFO SHALL be a sub-module, saturn_nibble_fifo, with push, pop, flush, head, count and async active-low reset.

Verification
REQ-019 Reset release, memory acks every cycle with data = addr[3:0] -> requests to 0,1,2,3; o_pc=0, o_nibble=0 valid one cycle after the first ack.
REQ-020 No i_inc_pc for 10 cycles -> exactly 4 completions, then o_bus_req=0; one pop -> one new request to addr 4.
REQ-021 i_load_pc with i_new_pc=20'h12345 while a request to 3 is waiting, ack 2 cycles later with data 4'hA -> 4'hA dropped; next request is to 12345; first o_pc=12345.
REQ-022 i_new_pc=20'hFFFFE, continuous acks and pops -> presented o_pc sequence FFFFE, FFFFF, 00000, 00001.
REQ-023 i_load_pc, i_inc_pc and i_bus_ack all on one edge with the FIFO full -> FIFO empty, acked data discarded, next request to i_new_pc.
REQ-024 i_reset pulsed low while o_bus_req=1 -> outputs clear immediately; first request after release is to address 0.

Source files
------------

// File: rtl/saturn_pkg.sv
// Saturn fetch shared types and sizes.
// Address/nibble widths, prefetch depth, fetch FSM encoding.
package saturn_pkg;

  localparam int AW    = 20;
  localparam int NW    = 4;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
  localparam int CW    = 3;

  typedef logic [AW-1:0] addr_t;
  typedef logic [NW-1:0] nib_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    addr_t addr;
    nib_t  nib;
  } fifo_ent_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_st_t;

endpackage

// File: rtl/saturn_nibble_fifo.sv
// Saturn prefetch queue: small ring of {addr, nibble} entries.
// Flush empties it in one edge; head reads zero when empty.
module saturn_nibble_fifo
  import saturn_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_push,
  input  logic      i_pop,
  input  logic      i_flush,
  input  fifo_ent_t i_data,
  output fifo_ent_t o_head,
  output cnt_t      o_count
);

  fifo_ent_t mem [DEPTH];
  ptr_t      rd_q;
  ptr_t      wr_q;
  cnt_t      cnt_q;
  logic      do_push;
  logic      do_pop;

  assign do_pop  = i_pop && (cnt_q != '0);
  assign do_push = i_push &&
                   ((cnt_q != cnt_t'(DEPTH)) || do_pop);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_q] <= i_data;
        wr_q      <= wr_q + ptr_t'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + ptr_t'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + cnt_t'(1);
        2'b01:   cnt_q <= cnt_q - cnt_t'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign o_head  = (cnt_q != '0) ? mem[rd_q] : '0;
  assign o_count = cnt_q;

endmodule

// File: rtl/saturn_fetch.sv
// Saturn nibble fetch unit: bus requester feeding a prefetch
// queue that presents one nibble at a time to the decoder.
module saturn_fetch
  import saturn_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_pc,
  input  logic [AW-1:0] i_new_pc,
  input  logic          i_inc_pc,
  output logic          o_bus_req,
  output logic [AW-1:0] o_bus_addr,
  input  logic          i_bus_ack,
  input  logic [NW-1:0] i_bus_data,
  output logic [AW-1:0] o_pc,
  output logic [NW-1:0] o_nibble,
  output logic          o_en_dec,
  output logic          o_stalled
);

  fetch_st_t st_q;
  fetch_st_t st_d;
  addr_t     req_q;
  addr_t     req_d;
  addr_t     rst_q;
  addr_t     rst_d;

  fifo_ent_t head;
  fifo_ent_t wdata;
  cnt_t      cnt;
  cnt_t      cnt_after;
  logic      done;
  logic      push;
  logic      pop;
  logic      space;

  assign o_bus_req  = (st_q != ST_IDLE);
  assign o_bus_addr = req_q;
  assign done       = o_bus_req && i_bus_ack;

  assign o_en_dec   = (cnt != '0);
  assign o_stalled  = !o_en_dec;
  assign o_pc       = head.addr;
  assign o_nibble   = head.nib;

  assign pop  = o_en_dec && i_inc_pc && !i_load_pc;
  assign push = done && (st_q == ST_REQ) && !i_load_pc;

  // Occupancy after this edge; one more fetch may start if it fits.
  assign cnt_after = cnt + cnt_t'(push) - cnt_t'(pop);
  assign space     = (cnt_after < cnt_t'(DEPTH));

  assign wdata.addr = req_q;
  assign wdata.nib  = i_bus_data;

  saturn_nibble_fifo u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (i_load_pc),
    .i_data  (wdata),
    .o_head  (head),
    .o_count (cnt)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      st_q  <= ST_IDLE;
      req_q <= '0;
      rst_q <= '0;
    end else begin
      st_q  <= st_d;
      req_q <= req_d;
      rst_q <= rst_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    req_d = req_q;
    rst_d = rst_q;
    unique case (st_q)
      ST_IDLE: begin
        if (i_load_pc) begin
          req_d = i_new_pc;
          st_d  = ST_REQ;
        end else if (space) begin
          st_d = ST_REQ;
        end
      end
      ST_REQ: begin
        unique case (1'b1)
          i_load_pc && !done: begin
            rst_d = i_new_pc;
            st_d  = ST_DISCARD;
          end
          i_load_pc && done: begin
            req_d = i_new_pc;
          end
          !i_load_pc && done: begin
            req_d = req_q + addr_t'(1);
            st_d  = space ? ST_REQ : ST_IDLE;
          end
          default: ;
        endcase
      end
      ST_DISCARD: begin
        // The bus address must hold until the stale read lands.
        if (done) begin
          req_d = i_load_pc ? i_new_pc : rst_q;
          st_d  = ST_REQ;
        end else if (i_load_pc) begin
          rst_d = i_new_pc;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_saturn_fetch.sv
// Directed bench for saturn_fetch.
// Memory returns addr[3:0] unless a test forces the data.
module tb_saturn_fetch;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_load_pc;
  logic [19:0] i_new_pc;
  logic        i_inc_pc;
  logic        o_bus_req;
  logic [19:0] o_bus_addr;
  logic        i_bus_ack;
  logic [3:0]  i_bus_data;
  logic [19:0] o_pc;
  logic [3:0]  o_nibble;
  logic        o_en_dec;
  logic        o_stalled;

  logic        auto_d;
  logic [3:0]  man_d;
  int          total = 0;
  int          bad = 0;

  always #5 i_clk = ~i_clk;

  always_comb i_bus_data = auto_d ? o_bus_addr[3:0] : man_d;

  saturn_fetch dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load_pc  (i_load_pc),
    .i_new_pc   (i_new_pc),
    .i_inc_pc   (i_inc_pc),
    .o_bus_req  (o_bus_req),
    .o_bus_addr (o_bus_addr),
    .i_bus_ack  (i_bus_ack),
    .i_bus_data (i_bus_data),
    .o_pc       (o_pc),
    .o_nibble   (o_nibble),
    .o_en_dec   (o_en_dec),
    .o_stalled  (o_stalled)
  );

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_reset   = 1'b0;
    i_load_pc = 1'b0;
    i_inc_pc  = 1'b0;
    i_bus_ack = 1'b0;
    i_new_pc  = '0;
    auto_d    = 1'b1;
    man_d     = '0;
    tick();
    tick();
    i_reset = 1'b1;
  endtask

  task automatic test_reset;
    i_reset   = 1'b0;
    i_load_pc = 1'b0;
    i_inc_pc  = 1'b0;
    i_bus_ack = 1'b0;
    i_new_pc  = '0;
    auto_d    = 1'b1;
    man_d     = '0;
    #2;
    total++;
    if ({o_en_dec, o_stalled, o_bus_req} !== 3'b010) begin
      bad++;
      $display("FAIL rst_flags got=%b want=010",
               {o_en_dec, o_stalled, o_bus_req});
    end
    total++;
    if ({o_bus_addr, o_pc, o_nibble} !== 44'h0) begin
      bad++;
      $display("FAIL rst_values got=%h want=0",
               {o_bus_addr, o_pc, o_nibble});
    end
    tick();
    i_reset = 1'b1;
    total++;
    if (o_bus_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_noreq got=%b want=0", o_bus_req);
    end
    tick();
    total++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, 20'h0}) begin
      bad++;
      $display("FAIL rst_firstreq got=%b/%h want=1/00000",
               o_bus_req, o_bus_addr);
    end
  endtask

  task automatic test_fill;
    int          comps;
    logic [19:0] seen [8];
    do_reset();
    comps     = 0;
    i_bus_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (o_bus_req && i_bus_ack) begin
        if (comps < 8) seen[comps] = o_bus_addr;
        comps++;
      end
      if (i == 1) begin
        total++;
        if (o_en_dec !== 1'b0) begin
          bad++;
          $display("FAIL fill_early got=%b want=0", o_en_dec);
        end
      end
      if (i == 2) begin
        total++;
        if ({o_en_dec, o_pc, o_nibble} !== {1'b1, 20'h0, 4'h0}) begin
          bad++;
          $display("FAIL fill_latency got=%b/%h/%h want=1/00000/0",
                   o_en_dec, o_pc, o_nibble);
        end
      end
      tick();
    end
    total++;
    if (comps !== 4) begin
      bad++;
      $display("FAIL fill_count got=%0d want=4", comps);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (seen[k] !== 20'(k)) begin
        bad++;
        $display("FAIL fill_addr%0d got=%h want=%h",
                 k, seen[k], 20'(k));
      end
    end
    total++;
    if ({o_bus_req, o_en_dec, o_stalled} !== 3'b010) begin
      bad++;
      $display("FAIL fill_full got=%b want=010",
               {o_bus_req, o_en_dec, o_stalled});
    end
    i_bus_ack = 1'b0;
    i_inc_pc  = 1'b1;
    tick();
    i_inc_pc = 1'b0;
    total++;
    if ({o_pc, o_nibble} !== {20'h1, 4'h1}) begin
      bad++;
      $display("FAIL pop_head got=%h/%h want=00001/1",
               o_pc, o_nibble);
    end
    total++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, 20'h4}) begin
      bad++;
      $display("FAIL pop_req got=%b/%h want=1/00004",
               o_bus_req, o_bus_addr);
    end
    tick();
    tick();
    total++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, 20'h4}) begin
      bad++;
      $display("FAIL req_stable got=%b/%h want=1/00004",
               o_bus_req, o_bus_addr);
    end
  endtask

  task automatic test_redirect;
    do_reset();
    tick();
    i_bus_ack = 1'b1;
    tick();
    tick();
    tick();
    i_bus_ack = 1'b0;
    total++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, 20'h3}) begin
      bad++;
      $display("FAIL redir_pre got=%b/%h want=1/00003",
               o_bus_req, o_bus_addr);
    end
    i_load_pc = 1'b1;
    i_new_pc  = 20'h12345;
    tick();
    i_load_pc = 1'b0;
    total++;
    if ({o_en_dec, o_stalled} !== 2'b01) begin
      bad++;
      $display("FAIL redir_flush got=%b want=01",
               {o_en_dec, o_stalled});
    end
    tick();
    total++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, 20'h3}) begin
      bad++;
      $display("FAIL redir_hold got=%b/%h want=1/00003",
               o_bus_req, o_bus_addr);
    end
    auto_d    = 1'b0;
    man_d     = 4'hA;
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    auto_d    = 1'b1;
    total++;
    if ({o_en_dec, o_bus_req, o_bus_addr} !== {2'b01, 20'h12345}) begin
      bad++;
      $display("FAIL redir_drop got=%b/%b/%h want=0/1/12345",
               o_en_dec, o_bus_req, o_bus_addr);
    end
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    total++;
    if ({o_en_dec, o_pc, o_nibble} !== {1'b1, 20'h12345, 4'h5}) begin
      bad++;
      $display("FAIL redir_first got=%b/%h/%h want=1/12345/5",
               o_en_dec, o_pc, o_nibble);
    end
    total++;
    if (o_bus_addr !== 20'h12346) begin
      bad++;
      $display("FAIL redir_next got=%h want=12346", o_bus_addr);
    end
  endtask

  task automatic test_wrap;
    logic [19:0] exp_pc [4];
    exp_pc[0] = 20'hFFFFE;
    exp_pc[1] = 20'hFFFFF;
    exp_pc[2] = 20'h00000;
    exp_pc[3] = 20'h00001;
    do_reset();
    tick();
    i_load_pc = 1'b1;
    i_new_pc  = 20'hFFFF0;
    tick();
    i_new_pc  = 20'hFFFFE;
    tick();
    i_load_pc = 1'b0;
    total++;
    if ({o_bus_req, o_bus_addr, o_en_dec} !== {1'b1, 20'h0, 1'b0}) begin
      bad++;
      $display("FAIL disc_hold got=%b/%h/%b want=1/00000/0",
               o_bus_req, o_bus_addr, o_en_dec);
    end
    i_bus_ack = 1'b1;
    tick();
    total++;
    if ({o_en_dec, o_bus_addr} !== {1'b0, 20'hFFFFE}) begin
      bad++;
      $display("FAIL disc_latest got=%b/%h want=0/ffffe",
               o_en_dec, o_bus_addr);
    end
    i_inc_pc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({o_en_dec, o_pc, o_nibble} !==
          {1'b1, exp_pc[k], exp_pc[k][3:0]}) begin
        bad++;
        $display("FAIL wrap%0d got=%b/%h/%h want=1/%h/%h",
                 k, o_en_dec, o_pc, o_nibble,
                 exp_pc[k], exp_pc[k][3:0]);
      end
    end
    i_inc_pc  = 1'b0;
    i_bus_ack = 1'b0;
  endtask

  task automatic test_collide_full;
    do_reset();
    i_bus_ack = 1'b1;
    repeat (5) tick();
    total++;
    if ({o_bus_req, o_en_dec} !== 2'b01) begin
      bad++;
      $display("FAIL full_pre got=%b want=01", {o_bus_req, o_en_dec});
    end
    i_load_pc = 1'b1;
    i_new_pc  = 20'hABCDE;
    i_inc_pc  = 1'b1;
    auto_d    = 1'b0;
    man_d     = 4'h7;
    tick();
    i_load_pc = 1'b0;
    i_inc_pc  = 1'b0;
    i_bus_ack = 1'b0;
    auto_d    = 1'b1;
    total++;
    if ({o_en_dec, o_bus_req, o_bus_addr} !== {2'b01, 20'hABCDE}) begin
      bad++;
      $display("FAIL full_coll got=%b/%b/%h want=0/1/abcde",
               o_en_dec, o_bus_req, o_bus_addr);
    end
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    total++;
    if ({o_en_dec, o_pc, o_nibble} !== {1'b1, 20'hABCDE, 4'hE}) begin
      bad++;
      $display("FAIL full_first got=%b/%h/%h want=1/abcde/e",
               o_en_dec, o_pc, o_nibble);
    end
  endtask

  task automatic test_collide_pending;
    do_reset();
    tick();
    i_bus_ack = 1'b1;
    repeat (3) tick();
    i_load_pc = 1'b1;
    i_new_pc  = 20'h55550;
    i_inc_pc  = 1'b1;
    auto_d    = 1'b0;
    man_d     = 4'h9;
    tick();
    i_load_pc = 1'b0;
    i_inc_pc  = 1'b0;
    i_bus_ack = 1'b0;
    auto_d    = 1'b1;
    total++;
    if ({o_en_dec, o_bus_req, o_bus_addr} !== {2'b01, 20'h55550}) begin
      bad++;
      $display("FAIL pend_coll got=%b/%b/%h want=0/1/55550",
               o_en_dec, o_bus_req, o_bus_addr);
    end
    i_bus_ack = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    total++;
    if ({o_en_dec, o_pc, o_nibble} !== {1'b1, 20'h55550, 4'h0}) begin
      bad++;
      $display("FAIL pend_first got=%b/%h/%h want=1/55550/0",
               o_en_dec, o_pc, o_nibble);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    tick();
    i_bus_ack = 1'b1;
    tick();
    tick();
    i_bus_ack = 1'b0;
    total++;
    if ({o_bus_req, o_bus_addr, o_en_dec} !== {1'b1, 20'h2, 1'b1}) begin
      bad++;
      $display("FAIL mid_pre got=%b/%h/%b want=1/00002/1",
               o_bus_req, o_bus_addr, o_en_dec);
    end
    i_reset = 1'b0;
    #1;
    total++;
    if ({o_bus_req, o_en_dec, o_stalled} !== 3'b001) begin
      bad++;
      $display("FAIL mid_flags got=%b want=001",
               {o_bus_req, o_en_dec, o_stalled});
    end
    total++;
    if ({o_bus_addr, o_pc, o_nibble} !== 44'h0) begin
      bad++;
      $display("FAIL mid_values got=%h want=0",
               {o_bus_addr, o_pc, o_nibble});
    end
    tick();
    i_reset = 1'b1;
    total++;
    if (o_bus_req !== 1'b0) begin
      bad++;
      $display("FAIL mid_noreq got=%b want=0", o_bus_req);
    end
    tick();
    total++;
    if ({o_bus_req, o_bus_addr, o_en_dec} !== {1'b1, 20'h0, 1'b0}) begin
      bad++;
      $display("FAIL mid_restart got=%b/%h/%b want=1/00000/0",
               o_bus_req, o_bus_addr, o_en_dec);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_redirect();
    test_wrap();
    test_collide_full();
    test_collide_pending();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
